tinyqv_data_responder: RTL

TINYQV_DATA_RESPONDER -- requirements
Module: tinyqv_data_responder

---
 rtl/tinyqv_resp_pkg.sv | 23 ++
 rtl/tinyqv_resp_ram.sv | 25 ++
 rtl/tinyqv_data_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tinyqv_resp_pkg.sv
// Shared definitions for the TinyQV data responder: access-size codes and FSM states.
package tinyqv_resp_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } resp_state_t;

    // Byte lanes touched by a store of the given size at the given byte offset.
    function automatic logic [3:0] store_lanes(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: store_lanes = 4'b0001 << offset;
            SIZE_HALF: store_lanes = offset[1] ? 4'b1100 : 4'b0011;
            default:   store_lanes = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/tinyqv_resp_ram.sv
// Word array with per-byte write enables and asynchronous read; contents survive reset.
module tinyqv_resp_ram #(
    parameter int ADDR_WORDS_LOG2 = 4
) (
    input  logic                       clk,
    input  logic [3:0]                 we,
    input  logic [ADDR_WORDS_LOG2-1:0] waddr,
    input  logic [31:0]                wdata,
    input  logic [ADDR_WORDS_LOG2-1:0] raddr,
    output logic [31:0]                rdata
);

    logic [31:0] mem [2**ADDR_WORDS_LOG2];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tinyqv_data_responder.sv
// Nibble-serial data memory responder for the TinyQV core.
// Optional address/alignment fault checking is enabled by defining TINYQV_RESP_ERR_EN.
module tinyqv_data_responder
    import tinyqv_resp_pkg::*;
#(
    parameter int ADDR_WORDS_LOG2 = 4,
    parameter int LATENCY         = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [2:0]  counter,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  mem_op,
    input  logic [27:0] addr_in,
    input  logic        address_ready,
    input  logic [3:0]  store_data,
    output logic [3:0]  load_data,
    output logic        load_data_ready,
    output logic        access_err
);

    localparam int         WB       = ADDR_WORDS_LOG2;
    localparam logic [1:0] LAT_INIT = 2'(LATENCY);

    resp_state_t   state, state_next;
    logic [1:0]    rounds, rounds_next;
    logic [31:0]   capture, capture_next;
    logic [WB-1:0] ld_idx;
    logic [1:0]    ld_off;
    logic          ld_err;
    logic          latch_load;
    logic          err_next;
    logic          fault;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic [31:0]   shifted;
    logic [1:0]    size;
    logic [WB-1:0] word_idx;
    logic          unused_bits;

    assign size     = mem_op[1:0];
    assign word_idx = addr_in[WB+1:2];

    // The nibble arriving at counter 7 is merged in combinationally so a store commits on that same edge.
    assign capture_next = {store_data, capture[31:4]};

`ifdef TINYQV_RESP_ERR_EN
    assign fault = (addr_in[27:WB+2] != '0)
                || ((size == SIZE_HALF) && addr_in[0])
                || ((size == SIZE_WORD) && (addr_in[1:0] != 2'b00));
    assign unused_bits = mem_op[2];
`else
    assign fault       = 1'b0;
    assign unused_bits = ^{mem_op[2], addr_in[27:WB+2]};
`endif

    always_comb begin
        case (size)
            SIZE_BYTE: ram_wdata = {4{capture_next[7:0]}};
            SIZE_HALF: ram_wdata = {2{capture_next[15:0]}};
            default:   ram_wdata = capture_next;
        endcase
    end

    // Any address presented while a load is in flight is dropped and flagged, in every build.
    always_comb begin
        state_next  = state;
        rounds_next = rounds;
        latch_load  = 1'b0;
        err_next    = 1'b0;
        ram_we      = 4'b0000;
        case (state)
            ST_IDLE: begin
                if (address_ready && is_store) begin
                    err_next = fault;
                    if (!fault && rstn) begin
                        ram_we = store_lanes(size, addr_in[1:0]);
                    end
                end else if (address_ready && is_load) begin
                    err_next    = fault;
                    latch_load  = 1'b1;
                    state_next  = ST_WAIT;
                    rounds_next = LAT_INIT;
                end
            end
            ST_WAIT: begin
                err_next = address_ready;
                if (counter == 3'd7) begin
                    if (rounds <= 2'd1) begin
                        state_next  = ST_RESPOND;
                        rounds_next = 2'd0;
                    end else begin
                        rounds_next = rounds - 2'd1;
                    end
                end
            end
            ST_RESPOND: begin
                err_next = address_ready;
                if (counter == 3'd7) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            rounds     <= 2'd0;
            access_err <= 1'b0;
        end else begin
            state      <= state_next;
            rounds     <= rounds_next;
            access_err <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (is_store) begin
            capture <= capture_next;
        end
        if (latch_load) begin
            ld_idx <= word_idx;
            ld_off <= addr_in[1:0];
            ld_err <= fault;
        end
    end

    tinyqv_resp_ram #(
        .ADDR_WORDS_LOG2(WB)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (word_idx),
        .wdata (ram_wdata),
        .raddr (ld_idx),
        .rdata (ram_rdata)
    );

    assign shifted         = ram_rdata >> {ld_off, 3'b000};
    assign load_data_ready = (state == ST_RESPOND);
    assign load_data       = (load_data_ready && !ld_err) ? shifted[{counter, 2'b00} +: 4] : 4'h0;

endmodule
